pipe_rca_adder: RTL and testbench
=================================

Name: pipe_rca_adder

Overview:
Parametrised pipelined ripple-carry adder/subtractor, successor to the 4-bit combinational RCA. The WIDTH-bit operands are split into CHUNK-bit slices. Each pipeline stage resolves one slice and passes its carry to the next stage through a register, so the datapath can run at high clock rates with one result per cycle. The block uses valid/ready handshakes on both sides and reports carry-out and signed overflow.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits resolved per stage; STAGES = WIDTH/CHUNK (latency).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand transfer request
in_ready  output  1  block can accept operands this cycle
a  input  WIDTH  operand A (unsigned or two's complement)
b  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0 = add, 1 = subtract
out_valid  output  1  result present
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  final carry out of bit WIDTH-1 (raw carry, not borrow)
ovf  output  1  signed overflow of the operation

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-low on rst_n. While rst_n=0, all stage valid bits, out_valid, sum, cout and ovf are 0. Asserting reset mid-operation discards all in-flight operations with no output.
- Operand conditioning at stage 0: bx = sub ? ~b : b; c0 = sub ? ~cin : cin. Add = a+b+cin; sub = a-b-cin.
- Stage k (0..STAGES-1) adds slice k of a and bx plus the registered carry from stage k-1 (c0 for k=0). It stores the slice result, the carry, the lower slices already resolved, and the untouched upper slices of a and bx.
- The sum/cout/ovf outputs come straight from the last stage register. Latency is exactly STAGES cycles from an in handshake to out_valid when there is no backpressure.
- ovf = carry into MSB XOR carry out of MSB, captured in the final stage.
- Handshake: advance = !out_valid || out_ready. in_ready = advance, a combinational function of out_valid/out_ready only, never of in_valid.
- When advance=1, all stage registers shift by one. Stage 0 loads in_valid and the operands.
- When advance=0, all stages hold, including bubbles (global stall).
- An operation is accepted when in_valid && in_ready. It is delivered when out_valid && out_ready.
- Simultaneous accept and deliver in one cycle is legal, giving full throughput of 1 op/cycle.
- Bubbles propagate as valid=0. Data on invalid stages is don't-care, but the outputs hold their last values while out_valid=0.
- Ordering is strictly FIFO, and no operation is lost or duplicated under any out_ready pattern.
- While out_valid=1 and out_ready=0, sum/cout/ovf stay stable.
- Wrap-around: the result is modulo 2^WIDTH, with the carry reported only on cout.

Decomposition:
- Package pipe_rca_pkg holds the default WIDTH/CHUNK, the STAGES derivation function, and an elaboration check that WIDTH % CHUNK == 0.
- One sub-module, rca_slice: a combinational CHUNK-bit ripple adder with inputs (a, b, cin) and outputs (sum, cout, c_msb_in). c_msb_in feeds ovf in the final slice.
- Instantiate rca_slice once per stage with a generate loop.

Test Plan:
1. Reset: hold rst_n=0 while driving in_valid=1 -> out_valid=0, sum=0, cout=0, ovf=0. Release reset, then pulse rst_n low during traffic -> in-flight ops vanish and out_valid=0 immediately.
2. Latency and add (WIDTH=16, CHUNK=4): a=16'h00FF, b=16'h0001, cin=0, sub=0, out_ready=1 -> 4 cycles later sum=16'h0100, cout=0, ovf=0. This carry ripples across the stages.
3. Wrap and overflow: a=16'hFFFF, b=16'h0001, cin=1 -> sum=16'h0001, cout=1, ovf=0. Then a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1.
4. Subtract: a=16'h0003, b=16'h0005, sub=1, cin=0 -> sum=16'hFFFE, cout=0, ovf=0. Then a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, cout=1, ovf=1.
5. Throughput: stream 8 back-to-back ops with out_ready=1 -> 8 consecutive out_valid cycles, in order, matching a reference model.
6. Backpressure: random out_ready over 200 random ops with random in_valid -> in_ready tracks advance, outputs stay stable while stalled, and the scoreboard shows no loss, duplication or reordering.

Source files
------------

// File: rtl/pipe_rca_pkg.sv
// Shared sizing defaults and configuration helpers for the pipelined RCA adder.
package pipe_rca_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CHUNK = 4;

  // Number of pipeline stages, one per CHUNK-bit slice.
  function automatic int unsigned calc_stages(input int unsigned width,
                                              input int unsigned chunk);
    return width / chunk;
  endfunction

  // Legal configuration: a nonzero chunk that tiles the word exactly.
  function automatic bit width_ok(input int unsigned width,
                                  input int unsigned chunk);
    return (chunk != 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/pipe_rca_adder_if.sv
// Operand/result handshake bundle for pipe_rca_adder.
interface pipe_rca_adder_if
  import pipe_rca_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Producer/consumer side: drives operands and accepts results.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/pipe_rca_adder_rca_slice.sv
// Combinational CHUNK-bit ripple-carry adder; also exposes the carry into its MSB.
module rca_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  // Bit-serial ripple through the slice.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice resolved per stage,
// global-stall valid/ready pipeline, carry-out and signed overflow at the output.
module pipe_rca_adder
  import pipe_rca_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_rca_adder_if.slave  bus
);

  localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);
  localparam int unsigned LAST   = STAGES - 1;
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  // Reject configurations where the slices do not tile the word.
  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("pipe_rca_adder: WIDTH must be a nonzero multiple of CHUNK");
  end

  // Stage registers: valid, operands (a and conditioned b), partial result, carry.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  r_q [STAGES];
  logic              ovf_q;

  // Per-stage inputs and slice results.
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] c_in;
  logic [WIDTH-1:0]  a_in  [STAGES];
  logic [WIDTH-1:0]  b_in  [STAGES];
  logic [WIDTH-1:0]  r_in  [STAGES];
  logic [WIDTH-1:0]  r_nxt [STAGES];
  logic [CHUNK-1:0]  s_w   [STAGES];
  logic              co_w  [STAGES];
  logic              cm_w  [STAGES];

  logic advance_c;

  // Whole pipeline moves together unless a held result is blocking the output.
  assign advance_c = !v_q[LAST] || bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      // Subtraction as a + ~b + ~borrow.
      assign v_in[k] = bus.in_valid;
      assign a_in[k] = bus.a;
      assign b_in[k] = bus.sub ? ~bus.b : bus.b;
      assign c_in[k] = bus.sub ? ~bus.cin : bus.cin;
      assign r_in[k] = '0;
    end else begin : g_body
      assign v_in[k] = v_q[k-1];
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign r_in[k] = r_q[k-1];
    end

    rca_slice #(
      .CHUNK (CHUNK)
    ) u_slice (
      .a        (a_in[k][k*CHUNK +: CHUNK]),
      .b        (b_in[k][k*CHUNK +: CHUNK]),
      .cin      (c_in[k]),
      .sum      (s_w[k]),
      .cout     (co_w[k]),
      .c_msb_in (cm_w[k])
    );

    // Merge this stage's slice into the partial result word.
    assign r_nxt[k] = (r_in[k] & ~(SLICE_MASK << (k * CHUNK)))
                    | (WIDTH'(s_w[k]) << (k * CHUNK));
  end

  // Pipeline registers; data only loads behind a valid op so outputs hold across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else if (advance_c) begin
      v_q <= v_in;
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (v_in[k]) begin
          a_q[k] <= a_in[k];
          b_q[k] <= b_in[k];
          r_q[k] <= r_nxt[k];
          c_q[k] <= co_w[k];
        end
      end
      if (v_in[LAST]) begin
        ovf_q <= co_w[LAST] ^ cm_w[LAST];
      end
    end
  end

  assign bus.in_ready  = advance_c;
  assign bus.out_valid = v_q[LAST];
  assign bus.sum       = r_q[LAST];
  assign bus.cout      = c_q[LAST];
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_rca_adder.sv
// Randomised bench for pipe_rca_adder with an arithmetic reference model and scoreboard.
module tb_pipe_rca_adder;

  localparam int unsigned W  = 16;
  localparam int unsigned C  = 4;
  localparam int unsigned ST = W / C;

  typedef struct packed {
    logic         ovf;
    logic         cout;
    logic [W-1:0] sum;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pipe_rca_adder_if #(.WIDTH(W)) bus ();

  pipe_rca_adder #(
    .WIDTH (W),
    .CHUNK (C)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  res_t expq[$];
  int   n_acc = 0;
  int   n_del = 0;
  int   cyc = 0;
  int   run_len = 0;
  int   last_del_cyc = -10;

  // Reference: plain integer arithmetic on the operation's meaning.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic s);
    int   ua, ub, sa, sb, ru, rs;
    res_t r;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      ru     = ua - ub - int'(ci);
      rs     = sa - sb - int'(ci);
      r.cout = (ru >= 0);
    end else begin
      ru     = ua + ub + int'(ci);
      rs     = sa + sb + int'(ci);
      r.cout = (ru >= (1 << W));
    end
    r.sum = W'(ru);
    r.ovf = (rs > ((1 << (W - 1)) - 1)) || (rs < -(1 << (W - 1)));
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle monitor: handshake rule, stall/idle stability, ordered scoreboard.
  res_t held, last_out, cur, e;
  bit   held_ok = 1'b0;
  bit   last_ok = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      expq.delete();
      held_ok = 1'b0;
      last_ok = 1'b0;
    end else begin
      cur = {bus.ovf, bus.cout, bus.sum};
      chk("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
      if (held_ok) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_data", 32'(cur), 32'(held));
      end
      if (last_ok && !bus.out_valid) begin
        chk("idle_hold", 32'(cur), 32'(last_out));
      end
      held_ok = bus.out_valid && !bus.out_ready;
      held    = cur;
      if (bus.out_valid && bus.out_ready) begin
        n_del++;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %h want none (t=%0t)", cur, $time);
        end else begin
          e = expq.pop_front();
          chk("result", 32'(cur), 32'(e));
        end
        run_len      = (last_del_cyc == cyc - 1) ? run_len + 1 : 1;
        last_del_cyc = cyc;
      end
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
        n_acc++;
      end
      last_out = cur;
      last_ok  = 1'b1;
    end
  end

  task automatic rand_op();
    bus.a   = W'($urandom);
    bus.b   = W'($urandom);
    bus.cin = 1'($urandom);
    bus.sub = 1'($urandom);
  endtask

  // Single op into an idle pipe; checks the model, latency and the DUT result.
  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic s, input res_t exp);
    int   lat;
    bit   got;
    res_t r;
    chk({name, "_model"}, 32'(model(a, b, ci, s)), 32'(exp));
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = ci;
    bus.sub       = s;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (lat < 12 && !got) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) got = 1'b1;
    end
    r = {bus.ovf, bus.cout, bus.sum};
    chk({name, "_latency"}, 32'(lat), 32'(ST));
    chk({name, "_dut"}, 32'(r), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, acc_local, guard;
    bit took;

    // Reset held with traffic present.
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    rand_op();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;

    // Directed arithmetic with hand-computed results.
    directed("add_ripple", 16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0100});
    directed("add_wrap",   16'hFFFF, 16'h0001, 1'b1, 1'b0, {1'b0, 1'b1, 16'h0001});
    directed("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
    directed("sub_neg",    16'h0003, 16'h0005, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    directed("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    directed("sub_borrow", 16'h0005, 16'h0004, 1'b1, 1'b1, {1'b0, 1'b1, 16'h0000});

    // Fill the pipe against a stalled output, then reset mid-flight.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_op();
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("stall_full_valid", 32'(bus.out_valid), 32'd1);
    d0    = n_del;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_sum", 32'(bus.sum), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("no_ghost_outputs", 32'(n_del), 32'(d0));

    // Back-to-back stream at full throughput.
    d0 = n_del;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      rand_op();
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("stream_count", 32'(n_del - d0), 32'd8);
    chk("stream_run", 32'(run_len), 32'd8);
    chk("stream_drained", 32'(expq.size()), 32'd0);

    // Random valid and backpressure.
    d0        = n_del;
    acc_local = 0;
    guard     = 0;
    took      = 1'b0;
    bus.in_valid = 1'b0;
    while (acc_local < 200 && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
      if (!bus.in_valid || took) begin
        rand_op();
        bus.in_valid = ($urandom_range(0, 3) != 0);
      end
      bus.out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      if (took) acc_local++;
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    while (expq.size() != 0 && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("rand_accepted", 32'(acc_local), 32'd200);
    chk("rand_delivered", 32'(n_del - d0), 32'd200);
    chk("rand_drained", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
